uart_rcv: RTL and testbench
===========================

UART_RCV -- requirements
Module: uart_rcv

Interface
REQ-001 BAUD_DIV, 434, clk cycles per bit (50 MHz / 115200); SHALL be an integer of at least 8.
REQ-002 clk  input  1  single system clock, rising-edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 RX  input  1  serial line (other end of TX on GPIO[3]); idle high, 8N1, LSB first.
REQ-005 clr_rdy  input  1  consumer acknowledge; clears rdy.
REQ-006 rx_data  output  8  last good received byte.
REQ-007 rdy  output  1  byte available; held until cleared.
REQ-008 frame_err  output  1  last frame had stop bit = 0; sticky until next start bit.
REQ-009 parity_err  output  1  present only when UART_RCV_PARITY_EN is defined; see Configuration.

Function
REQ-010 RX SHALL pass through a two-flop synchronizer, and all logic SHALL use the synchronized value.
REQ-011 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-012 IDLE: a synchronized high-to-low transition SHALL move the FSM to START and load the baud counter with BAUD_DIV/2 (integer division).
REQ-013 START: when the counter expires, RX=0 SHALL move the FSM to DATA; RX=1 (glitch) SHALL return it to IDLE with no flag change.
REQ-014 DATA: RX SHALL be sampled every BAUD_DIV cycles and shifted in LSB first; after the 8th sample the FSM SHALL go to STOP (or PARITY, see Configuration).
REQ-015 STOP: sample = 1 SHALL load rx_data and set rdy in the same cycle; sample = 0 SHALL set frame_err and leave rx_data and rdy unchanged; either way the FSM SHALL return to IDLE.
REQ-016 rdy SHALL clear on clr_rdy or on a new start detection; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-017 frame_err (and parity_err) SHALL clear on the next start detection.
REQ-018 Latency: rdy SHALL assert 2 + BAUD_DIV/2 + 9*BAUD_DIV (+/-1) cycles after the RX falling edge at the pin.
REQ-019 The baud counter SHALL be $clog2(BAUD_DIV+1) bits wide and the bit counter 4 bits; neither SHALL wrap mid-frame.
REQ-020 A low RX seen in STOP SHALL NOT be treated as a start bit; back-to-back frames SHALL be accepted from IDLE on the next falling edge.
REQ-021 RX held permanently low SHALL produce exactly one frame_err and then no further frames until RX returns high.

Reset
REQ-022 On rst_n=0 the block SHALL asynchronously set the FSM to IDLE, rx_data=8'h00, rdy=0, frame_err=0 and parity_err=0.
REQ-023 On rst_n=0 the synchronizer flops SHALL reset to 1 so that reset release does not produce a false start.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no flag set.

Configuration
REQ-025 Macro UART_RCV_PARITY_EN, when defined, SHALL add a PARITY state between DATA and STOP that samples one even-parity bit.
REQ-026 With the macro, a parity mismatch SHALL set parity_err, rdy SHALL still set, and rx_data SHALL still load if the stop bit is good.
REQ-027 With the macro, the frame SHALL be 11 bits and the latency in REQ-018 SHALL grow by BAUD_DIV.
REQ-028 Without the macro, the frame SHALL be 10 bits and the parity_err port and PARITY state SHALL be absent.

Verification (BAUD_DIV=16)
REQ-029 Send 8'hA5 with a good stop bit -> rx_data=8'hA5, rdy=1 at 2+8+144 cycles (+/-1), frame_err=0.
REQ-030 Drive a 4-cycle low glitch on idle RX -> FSM returns to IDLE, rdy=0, frame_err=0.
REQ-031 Send 8'h3C with stop bit = 0 -> frame_err=1, rdy=0, rx_data keeps its prior value.
REQ-032 Send 8'h55 then 8'hAA back-to-back with no clr_rdy -> rdy drops at the second start, then rx_data=8'hAA and rdy=1; pulse clr_rdy -> rdy=0 next cycle.
REQ-033 Assert rst_n=0 after bit 4 of 8'hFF -> all outputs are 0 immediately; the next frame 8'h01 is received correctly.
REQ-034 With UART_RCV_PARITY_EN, send 8'h07 with parity bit 0 -> parity_err=1, rdy=1, rx_data=8'h07.

Source files
------------

// File: rtl/uart_rcv.sv
// 8N1 UART receiver with a two-flop RX synchronizer and mid-bit sampling.
// Define UART_RCV_PARITY_EN to add an even-parity bit and the parity_err output.
//
// state  | meaning
// IDLE   | line idle, waiting for a synchronized falling edge
// START  | half-bit wait, then confirm the start bit is still low
// DATA   | sample 8 data bits, LSB first, one per BAUD_DIV cycles
// PARITY | sample the even-parity bit (UART_RCV_PARITY_EN only)
// STOP   | sample the stop bit, publish the byte or flag a framing error
module uart_rcv #(
   parameter int BAUD_DIV = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy,
`ifdef UART_RCV_PARITY_EN
   output logic       parity_err,
`endif
   output logic       frame_err
);

   localparam int               CNT_W    = $clog2(BAUD_DIV + 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_RCV_PARITY_EN
      PARITY = 3'd4,
`endif
      STOP   = 3'd3
   } state_t;

   state_t     state_q, state_d;
   logic       rx_meta_q, rx_sync_q, rx_prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rdy_q, rdy_d;
   logic       ferr_q, ferr_d;
`ifdef UART_RCV_PARITY_EN
   logic       perr_q, perr_d;
`endif
   logic       tick;
   logic       start_det;

   // Synchronizer resets high so reset release never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= RX;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   assign tick      = (cnt_q == CNT_ONE);
   assign start_det = (state_q == IDLE) && rx_prev_q && !rx_sync_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      rx_data_d = rx_data_q;
      rdy_d     = rdy_q;
      ferr_d    = ferr_q;
`ifdef UART_RCV_PARITY_EN
      perr_d    = perr_q;
`endif
      if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_ONE;
      end
      // Clear first so that a set later in the same cycle takes priority.
      if (clr_rdy) begin
         rdy_d = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (start_det) begin
               state_d = START;
               cnt_d   = CNT_HALF;
               rdy_d   = 1'b0;
               ferr_d  = 1'b0;
`ifdef UART_RCV_PARITY_EN
               perr_d  = 1'b0;
`endif
            end
         end
         START: begin
            if (tick) begin
               if (!rx_sync_q) begin
                  state_d = DATA;
                  cnt_d   = CNT_FULL;
                  bit_d   = 4'd0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (tick) begin
               shift_d = {rx_sync_q, shift_q[7:1]};
               cnt_d   = CNT_FULL;
               if (bit_q == 4'd7) begin
`ifdef UART_RCV_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
`ifdef UART_RCV_PARITY_EN
         PARITY: begin
            if (tick) begin
               if (rx_sync_q != (^shift_q)) begin
                  perr_d = 1'b1;
               end
               cnt_d   = CNT_FULL;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (rx_sync_q) begin
                  rx_data_d = shift_q;
                  rdy_d     = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= 4'd0;
         shift_q   <= 8'h00;
         rx_data_q <= 8'h00;
         rdy_q     <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RCV_PARITY_EN
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         rx_data_q <= rx_data_d;
         rdy_q     <= rdy_d;
         ferr_q    <= ferr_d;
`ifdef UART_RCV_PARITY_EN
         perr_q    <= perr_d;
`endif
      end
   end

   assign rx_data   = rx_data_q;
   assign rdy       = rdy_q;
   assign frame_err = ferr_q;
`ifdef UART_RCV_PARITY_EN
   assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rcv.sv
// Directed self-checking bench for uart_rcv at BAUD_DIV=16.
module tb_uart_rcv;

   localparam int BAUD = 16;
`ifdef UART_RCV_PARITY_EN
   localparam int LAT_EXP = 2 + 8 + 144 + 16;
`else
   localparam int LAT_EXP = 2 + 8 + 144;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       RX = 1'b1;
   logic       clr_rdy = 1'b0;
   logic [7:0] rx_data;
   logic       rdy;
   logic       frame_err;
`ifdef UART_RCV_PARITY_EN
   logic       parity_err;
   logic       par_flip = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   uart_rcv #(.BAUD_DIV(BAUD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .RX        (RX),
      .clr_rdy   (clr_rdy),
      .rx_data   (rx_data),
      .rdy       (rdy),
`ifdef UART_RCV_PARITY_EN
      .parity_err(parity_err),
`endif
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   // All tasks start and end 1 time unit after a rising edge.
   task automatic send_bit(input logic b);
      RX = b;
      repeat (BAUD) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RCV_PARITY_EN
      send_bit((^d) ^ par_flip);
`endif
      send_bit(stop_b);
      RX = 1'b1;
   endtask

   task automatic idle(input int n);
      RX = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      clr_rdy = 1'b1;
      @(posedge clk);
      #1;
      clr_rdy = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      RX    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", rdy); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
`ifdef UART_RCV_PARITY_EN
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
`endif
      rst_n = 1'b1;
      idle(5);
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_release_rdy got %b want 0", rdy); end
   endtask

   task automatic test_good_frame();
      int lat;
      lat = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            while (lat < 400) begin
               @(posedge clk);
               #1;
               lat++;
               if (rdy === 1'b1) break;
            end
         end
      join
      checks++;
      if (lat >= 400 || lat < LAT_EXP - 1 || lat > LAT_EXP + 1) begin
         errors++; $display("FAIL good_latency got %0d want %0d +/-1", lat, LAT_EXP);
      end
      checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL good_rx_data got %h want a5", rx_data); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL good_rdy got %b want 1", rdy); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL good_frame_err got %b want 0", frame_err); end
`ifdef UART_RCV_PARITY_EN
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL good_parity_err got %b want 0", parity_err); end
`endif
      idle(4);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL good_rdy_held got %b want 1", rdy); end
      pulse_clr();
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL good_clr_rdy got %b want 0", rdy); end
   endtask

   task automatic test_glitch();
      RX = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      idle(40);
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL glitch_rdy got %b want 0", rdy); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_frame_err got %b want 0", frame_err); end
      checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL glitch_rx_data got %h want a5", rx_data); end
   endtask

   task automatic test_frame_err();
      send_frame(8'h3C, 1'b0);
      idle(20);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", frame_err); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL ferr_rdy got %b want 0", rdy); end
      checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL ferr_rx_data got %h want a5", rx_data); end
   endtask

   task automatic test_back_to_back();
      send_frame(8'h55, 1'b1);
      checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL b2b_first_data got %h want 55", rx_data); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_first_rdy got %b want 1", rdy); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL b2b_ferr_cleared got %b want 0", frame_err); end
      send_bit(1'b0);
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_rdy_drop got %b want 0", rdy); end
      for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b1 : 1'b0);
`ifdef UART_RCV_PARITY_EN
      send_bit(1'b0);
`endif
      send_bit(1'b1);
      checks++; if (rx_data !== 8'hAA) begin errors++; $display("FAIL b2b_second_data got %h want aa", rx_data); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_second_rdy got %b want 1", rdy); end
      pulse_clr();
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_clr_rdy got %b want 0", rdy); end
   endtask

   task automatic test_reset_mid_frame();
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      #3;
      rst_n = 1'b0;
      #2;
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_rx_data got %h want 00", rx_data); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL midrst_rdy got %b want 0", rdy); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err got %b want 0", frame_err); end
      RX = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(BAUD * 12);
      checks++; if (frame_err !== 1'b0 || rdy !== 1'b0) begin errors++; $display("FAIL midrst_no_flag got ferr=%b rdy=%b want 0 0", frame_err, rdy); end
      send_frame(8'h01, 1'b1);
      checks++; if (rx_data !== 8'h01) begin errors++; $display("FAIL midrst_next_data got %h want 01", rx_data); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL midrst_next_rdy got %b want 1", rdy); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_next_ferr got %b want 0", frame_err); end
   endtask

`ifdef UART_RCV_PARITY_EN
   task automatic test_parity();
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1);
      par_flip = 1'b0;
      checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_err got %b want 1", parity_err); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL par_rdy got %b want 1", rdy); end
      checks++; if (rx_data !== 8'h07) begin errors++; $display("FAIL par_rx_data got %h want 07", rx_data); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL par_frame_err got %b want 0", frame_err); end
      pulse_clr();
   endtask
`endif

   task automatic test_held_low();
      int drops;
      drops = 0;
      pulse_clr();
      RX = 1'b0;
      repeat (200) @(posedge clk);
      #1;
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL held_frame_err got %b want 1", frame_err); end
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (frame_err !== 1'b1) drops++;
      end
      checks++; if (drops != 0) begin errors++; $display("FAIL held_sticky got %0d drops want 0", drops); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL held_rdy got %b want 0", rdy); end
      checks++; if (rx_data !== 8'h01) begin errors++; $display("FAIL held_rx_data got %h want 01", rx_data); end
      idle(40);
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef UART_RCV_PARITY_EN
      test_parity();
`endif
      test_held_low();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
